fetch_unit: RTL and testbench

- Instruction-fetch stage of the single-cycle-to-pipelined RISC core. It sits directly upstream of the instruction memory.
- Owns the program counter, drives the byte address into the combinational instruction memory, and captures the returned word into an IF/ID register for the decoder.
- Handles stall, branch/jump redirect with flush, and out-of-range or misaligned fetch faults.

---
 rtl/fetch_unit.sv | 118 +++++++++++
 tb/tb_fetch_unit.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage.
// Owns the program counter, presents it to a combinational instruction
// memory and registers the returned word into the IF/ID pipeline register.
// Handles stall, redirect with flush, and sticky fetch faults for
// misaligned or out-of-range addresses.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   stall              hold pc and IF/ID this cycle
//   redirect           taken branch/jump; priority over stall
//   redirect_target    new pc when redirect=1
//   imem_addr          byte address to instruction memory (= pc)
//   imem_rdata         instruction word for imem_addr
//   if_id_instr        registered instruction
//   if_id_pc           pc of if_id_instr
//   if_id_pc_plus4     link value if_id_pc+4
//   if_id_valid        if_id_instr is a real instruction
//   fault, fault_pc    sticky fault flag and offending address
//
// state | meaning
// ------+------------------------------------------------------------
// BOOT  | one bubble cycle after reset so the memory address settles
// RUN   | normal fetch, stall and redirect handling
// FAULT | bad fetch address seen; everything frozen until reset

module fetch_unit #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_0000,
    parameter logic [WIDTH-1:0] IMEM_LAST = 32'd508,
    parameter logic [WIDTH-1:0] NOP_WORD  = 32'h0000_0013
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_target,
    output logic [WIDTH-1:0] imem_addr,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic [WIDTH-1:0] if_id_instr,
    output logic [WIDTH-1:0] if_id_pc,
    output logic [WIDTH-1:0] if_id_pc_plus4,
    output logic             if_id_valid,
    output logic             fault,
    output logic [WIDTH-1:0] fault_pc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        FAULT = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] pc_plus4;
    logic             target_bad;
    logic             seq_bad;

    // pc+4 wraps modulo 2^WIDTH; the unsigned compare flags overruns.
    assign pc_plus4   = pc + WIDTH'(4);
    assign target_bad = (redirect_target[1:0] != 2'b00) || (redirect_target > IMEM_LAST);
    assign seq_bad    = (pc_plus4 > IMEM_LAST);
    assign imem_addr  = pc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_PC;
            if_id_instr    <= '0;
            if_id_pc       <= '0;
            if_id_pc_plus4 <= '0;
            if_id_valid    <= 1'b0;
            fault          <= 1'b0;
            fault_pc       <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end

                RUN: begin
                    if (redirect) begin
                        // Flush: the in-flight word is replaced, its pc fields hold.
                        pc          <= redirect_target;
                        if_id_instr <= NOP_WORD;
                        if_id_valid <= 1'b0;
                        if (target_bad) begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            fault_pc <= redirect_target;
                        end
                    end else if (!stall) begin
                        if_id_instr    <= imem_rdata;
                        if_id_pc       <= pc;
                        if_id_pc_plus4 <= pc_plus4;
                        if_id_valid    <= 1'b1;
                        pc             <= pc_plus4;
                        // The word at pc is still good; only the next fetch is illegal.
                        if (seq_bad) begin
                            state    <= FAULT;
                            fault    <= 1'b1;
                            fault_pc <= pc_plus4;
                        end
                    end
                end

                FAULT: begin
                    if_id_valid <= 1'b0;
                end

                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic        if_id_valid;
    logic        fault;
    logic [31:0] fault_pc;

    int tests;
    int failed;

    logic [31:0] mem [0:511];

    fetch_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_rdata      (imem_rdata),
        .if_id_instr     (if_id_instr),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_valid     (if_id_valid),
        .fault           (fault),
        .fault_pc        (fault_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign imem_rdata = (imem_addr < 32'd512) ? mem[imem_addr[8:0]] : 32'h0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_target = '0;
        #12;
        tests++;
        if ({if_id_instr, if_id_pc, if_id_pc_plus4, fault_pc} !== 128'h0 ||
            if_id_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin
            failed++;
            $display("FAIL reset_values: instr=%h pc=%h pc4=%h valid=%b fault=%b fpc=%h addr=%h",
                     if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault, fault_pc, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        step();
        tests++;
        if (if_id_valid !== 1'b0) begin
            failed++; $display("FAIL boot_bubble: valid=%b want 0", if_id_valid);
        end
        step();
        tests++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h002081B3 ||
            if_id_pc_plus4 !== 32'h4 || if_id_valid !== 1'b1) begin
            failed++;
            $display("FAIL first_fetch: pc=%h instr=%h pc4=%h valid=%b want 0/002081b3/4/1",
                     if_id_pc, if_id_instr, if_id_pc_plus4, if_id_valid);
        end
        step();
        tests++;
        if (if_id_pc !== 32'h4 || if_id_instr !== 32'h403202B3 || if_id_pc_plus4 !== 32'h8) begin
            failed++;
            $display("FAIL second_fetch: pc=%h instr=%h pc4=%h want 4/403202b3/8",
                     if_id_pc, if_id_instr, if_id_pc_plus4);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            tests++;
            if (imem_addr !== 32'h8 || if_id_pc !== 32'h4 ||
                if_id_instr !== 32'h403202B3 || if_id_valid !== 1'b1) begin
                failed++;
                $display("FAIL stall_hold[%0d]: addr=%h pc=%h instr=%h valid=%b want 8/4/403202b3/1",
                         i, imem_addr, if_id_pc, if_id_instr, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        tests++;
        if (if_id_pc !== 32'h8 || if_id_instr !== 32'hC0DE0008 || if_id_pc_plus4 !== 32'hC) begin
            failed++;
            $display("FAIL stall_release: pc=%h instr=%h pc4=%h want 8/c0de0008/c",
                     if_id_pc, if_id_instr, if_id_pc_plus4);
        end
    endtask

    task automatic test_redirect();
        redirect = 1'b1; redirect_target = 32'h30; stall = 1'b1;
        step();
        redirect = 1'b0; stall = 1'b0;
        tests++;
        if (if_id_valid !== 1'b0 || if_id_instr !== 32'h13 ||
            if_id_pc !== 32'h8 || imem_addr !== 32'h30 || fault !== 1'b0) begin
            failed++;
            $display("FAIL redirect_flush: valid=%b instr=%h pc=%h addr=%h fault=%b want 0/13/8/30/0",
                     if_id_valid, if_id_instr, if_id_pc, imem_addr, fault);
        end
        step();
        tests++;
        if (if_id_pc !== 32'h30 || if_id_instr !== 32'h00110293 ||
            if_id_pc_plus4 !== 32'h34 || if_id_valid !== 1'b1) begin
            failed++;
            $display("FAIL redirect_fetch: pc=%h instr=%h pc4=%h valid=%b want 30/00110293/34/1",
                     if_id_pc, if_id_instr, if_id_pc_plus4, if_id_valid);
        end
    endtask

    task automatic test_misaligned();
        redirect = 1'b1; redirect_target = 32'h32;
        step();
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'h32 || if_id_valid !== 1'b0 || imem_addr !== 32'h32) begin
            failed++;
            $display("FAIL misaligned_fault: fault=%b fpc=%h valid=%b addr=%h want 1/32/0/32",
                     fault, fault_pc, if_id_valid, imem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            redirect = ~redirect; redirect_target = 32'h40; stall = ~stall;
            step();
            tests++;
            if (fault !== 1'b1 || fault_pc !== 32'h32 || imem_addr !== 32'h32 ||
                if_id_valid !== 1'b0 || if_id_pc !== 32'h30) begin
                failed++;
                $display("FAIL fault_frozen[%0d]: fault=%b fpc=%h addr=%h valid=%b pc=%h want 1/32/32/0/30",
                         i, fault, fault_pc, imem_addr, if_id_valid, if_id_pc);
            end
        end
        redirect = 1'b0; stall = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (fault !== 1'b0 || fault_pc !== 32'h0 || imem_addr !== 32'h0) begin
            failed++;
            $display("FAIL fault_cleared: fault=%b fpc=%h addr=%h want 0/0/0", fault, fault_pc, imem_addr);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq_fault();
        step();
        redirect = 1'b1; redirect_target = 32'd504;
        step();
        redirect = 1'b0;
        step();
        tests++;
        if (if_id_pc !== 32'd504 || if_id_instr !== 32'hC0DE01F8 || if_id_valid !== 1'b1 || fault !== 1'b0) begin
            failed++;
            $display("FAIL seq_504: pc=%h instr=%h valid=%b fault=%b want 1f8/c0de01f8/1/0",
                     if_id_pc, if_id_instr, if_id_valid, fault);
        end
        step();
        tests++;
        if (if_id_pc !== 32'd508 || if_id_instr !== 32'hC0DE01FC ||
            if_id_pc_plus4 !== 32'd512 || if_id_valid !== 1'b1 || imem_addr !== 32'd512) begin
            failed++;
            $display("FAIL seq_508: pc=%h instr=%h pc4=%h valid=%b addr=%h want 1fc/c0de01fc/200/1/200",
                     if_id_pc, if_id_instr, if_id_pc_plus4, if_id_valid, imem_addr);
        end
        step();
        tests++;
        if (fault !== 1'b1 || fault_pc !== 32'd512 || if_id_valid !== 1'b0 || imem_addr !== 32'd512) begin
            failed++;
            $display("FAIL seq_fault: fault=%b fpc=%h valid=%b addr=%h want 1/200/0/200",
                     fault, fault_pc, if_id_valid, imem_addr);
        end
    endtask

    task automatic test_async_reset();
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        step();
        step();
        step();
        tests++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'h4) begin
            failed++; $display("FAIL pre_reset_run: valid=%b pc=%h want 1/4", if_id_valid, if_id_pc);
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({if_id_instr, if_id_pc, if_id_pc_plus4, fault_pc} !== 128'h0 ||
            if_id_valid !== 1'b0 || fault !== 1'b0 || imem_addr !== 32'h0) begin
            failed++;
            $display("FAIL async_reset: instr=%h pc=%h pc4=%h valid=%b fault=%b fpc=%h addr=%h",
                     if_id_instr, if_id_pc, if_id_pc_plus4, if_id_valid, fault, fault_pc, imem_addr);
        end
        #1 rst_n = 1'b1;
        step();
        tests++;
        if (if_id_valid !== 1'b0 || imem_addr !== 32'h0) begin
            failed++; $display("FAIL reboot_bubble: valid=%b addr=%h want 0/0", if_id_valid, imem_addr);
        end
        step();
        tests++;
        if (if_id_pc !== 32'h0 || if_id_instr !== 32'h002081B3 || if_id_valid !== 1'b1) begin
            failed++;
            $display("FAIL reboot_fetch: pc=%h instr=%h valid=%b want 0/002081b3/1",
                     if_id_pc, if_id_instr, if_id_valid);
        end
    endtask

    initial begin
        tests = 0;
        failed = 0;
        for (int a = 0; a < 512; a++) mem[a] = 32'hC0DE0000 | a;
        mem[0]    = 32'h002081B3;
        mem[4]    = 32'h403202B3;
        mem[9'h30] = 32'h00110293;

        test_reset();
        test_fetch();
        test_stall();
        test_redirect();
        test_misaligned();
        test_seq_fault();
        test_async_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
